// File: rtl/mux4way_rr.sv
// mux4way_rr: four-channel valid/ready round-robin merge into one registered output slot
module mux4way_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic             v0,
  input  logic             v1,
  input  logic             v2,
  input  logic             v3,
  output logic             r0,
  output logic             r1,
  output logic             r2,
  output logic             r3,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel_1,
  output logic             sel_0
);
  logic [1:0] last, g, p1, p2, p3, sel;
  logic [3:0] v, r;
  logic gnt;
  logic [WIDTH-1:0] ag;
  always_comb begin
    v = {v3, v2, v1, v0};
    p1 = last + 2'd1;
    p2 = last + 2'd2;
    p3 = last + 2'd3;
    g = v[p1] ? p1 : v[p2] ? p2 : v[p3] ? p3 : last;
    gnt = !rst && (!y_valid || y_ready) && |v;
    r = gnt ? 4'b0001 << g : 4'b0000;
    ag = g == 2'd0 ? a0 : g == 2'd1 ? a1 : g == 2'd2 ? a2 : a3;
  end
  assign {r3, r2, r1, r0} = r;
  assign {sel_1, sel_0} = sel;
  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid <= 1'b0;
      y <= '0;
      sel <= 2'd0;
      last <= 2'd3;
    end else if (gnt) begin
      y_valid <= 1'b1;
      y <= ag;
      sel <= g;
      last <= g;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux4way_rr.sv
// tb_mux4way_rr: table-driven check of mux4way_rr with a scoreboard of granted words
module tb_mux4way_rr;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] a0 = 8'h0, a1 = 8'h0, a2 = 8'h0, a3 = 8'h0;
  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic r0, r1, r2, r3, y_valid, y_ready = 1'b0, sel_1, sel_0;
  logic [7:0] y;
  int tests = 0, fails = 0;
  logic [9:0] sb[$];
  logic [7:0] last_y;
  logic [1:0] last_sel;
  typedef struct {
    logic rs;
    logic [3:0] v;
    logic yr;
    logic [7:0] base;
    logic [3:0] er;
    logic ev;
  } vec_t;
  vec_t tbl[29];

  mux4way_rr #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3), .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel_1(sel_1), .sel_0(sel_0)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic rs, input logic [3:0] vv, input logic yr,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [7:0] d3, input logic [3:0] er, input logic ev);
    logic [1:0] k;
    logic [7:0] d;
    logic [9:0] e;
    @(negedge clk);
    rst = rs;
    {v3, v2, v1, v0} = vv;
    y_ready = yr;
    {a0, a1, a2, a3} = {d0, d1, d2, d3};
    if (er != 4'b0) begin
      k = er[1] ? 2'd1 : er[2] ? 2'd2 : er[3] ? 2'd3 : 2'd0;
      d = k == 2'd0 ? d0 : k == 2'd1 ? d1 : k == 2'd2 ? d2 : d3;
      sb.push_back({k, d});
    end
    #1 check({nm, " ready"}, {r3, r2, r1, r0}, er);
    @(posedge clk);
    #1;
    if (rs) begin
      last_y = 8'h0;
      last_sel = 2'd0;
    end else if (er != 4'b0) begin
      e = sb.pop_front();
      {last_sel, last_y} = e;
    end
    check({nm, " y_valid"}, y_valid, ev);
    check({nm, " y"}, y, last_y);
    check({nm, " sel"}, {sel_1, sel_0}, last_sel);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'hf, 1'b1, 8'h10, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'h2, 1'b1, 8'h59, 4'b0010, 1'b1};
    tbl[2]  = '{1'b0, 4'h0, 1'b1, 8'h00, 4'b0000, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 1'b1, 8'h00, 4'b0000, 1'b0};
    tbl[4]  = '{1'b1, 4'hf, 1'b1, 8'h10, 4'b0000, 1'b0};
    for (int i = 0; i < 8; i++) tbl[5 + i] = '{1'b0, 4'hf, 1'b1, 8'h10, 4'b0001 << (i % 4), 1'b1};
    tbl[13] = '{1'b0, 4'hf, 1'b1, 8'h22, 4'b0001, 1'b1};
    for (int i = 0; i < 5; i++) tbl[14 + i] = '{1'b0, 4'hf, 1'b0, 8'h30 + 8'(i * 16), 4'b0000, 1'b1};
    tbl[19] = '{1'b1, 4'hf, 1'b0, 8'h90, 4'b0000, 1'b0};
    tbl[20] = '{1'b0, 4'hf, 1'b0, 8'h40, 4'b0001, 1'b1};
    tbl[21] = '{1'b0, 4'h8, 1'b1, 8'h50, 4'b1000, 1'b1};
    tbl[22] = '{1'b0, 4'h9, 1'b1, 8'h60, 4'b0001, 1'b1};
    tbl[23] = '{1'b0, 4'h9, 1'b1, 8'h70, 4'b1000, 1'b1};
    tbl[24] = '{1'b0, 4'h6, 1'b1, 8'h80, 4'b0010, 1'b1};
    tbl[25] = '{1'b0, 4'h6, 1'b1, 8'h90, 4'b0100, 1'b1};
    tbl[26] = '{1'b0, 4'h6, 1'b1, 8'ha0, 4'b0010, 1'b1};
    tbl[27] = '{1'b0, 4'h0, 1'b0, 8'hb0, 4'b0000, 1'b1};
    tbl[28] = '{1'b0, 4'h0, 1'b1, 8'hb0, 4'b0000, 1'b0};
    last_y = 8'h0;
    last_sel = 2'd0;
    for (int i = 0; i < 29; i++)
      step($sformatf("row%0d", i), tbl[i].rs, tbl[i].v, tbl[i].yr, tbl[i].base,
           tbl[i].base + 8'd1, tbl[i].base + 8'd2, tbl[i].base + 8'd3, tbl[i].er, tbl[i].ev);
    step("fill2", 1'b0, 4'h4, 1'b1, 8'h01, 8'h02, 8'hc3, 8'h04, 4'b0100, 1'b1);
    for (int i = 0; i < 4; i++)
      step($sformatf("stall%0d", i), 1'b0, 4'hf, 1'b0, 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 4'b0000, 1'b1);
    step("drain", 1'b0, 4'h0, 1'b1, 8'hee, 8'hee, 8'hee, 8'hee, 4'b0000, 1'b0);
    step("idle", 1'b0, 4'h0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0);
    check("scoreboard empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux4way_rr.md
MUX4WAY_RR -- requirements
Module: mux4way_rr

Interface
REQ-001 Parameter WIDTH, default 8: data width of every input channel and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a0, a1, a2, a3  input  WIDTH each  channel data, inputs 0..3.
REQ-005 v0, v1, v2, v3  input  1 each  channel valid, inputs 0..3.
REQ-006 r0, r1, r2, r3  output  1 each  channel ready, inputs 0..3; combinational.
REQ-007 y  output  WIDTH  merged output data, registered.
REQ-008 y_valid  output  1  output valid, registered.
REQ-009 y_ready  input  1  downstream ready.
REQ-010 sel_1, sel_0  output  1 each  source index of the word held in y (sel_1 = MSB); registered.

Function
REQ-011 Block merges four valid/ready channels into one output; it is the collector for the existing dmux4way fan-out path.
REQ-012 Transfer on channel k: vk=1 and rk=1 on the same rising edge. Output transfer: y_valid=1 and y_ready=1 on the same edge.
REQ-013 States: EMPTY (y_valid=0) and FULL (y_valid=1); 2-bit last-grant pointer L.
REQ-014 Slot free = EMPTY, or FULL with y_ready=1.
REQ-015 If slot free and at least one vk=1: grant exactly one channel g, first requester in order L+1, L+2, L+3, L (mod 4); rg=1, all other r=0.
REQ-016 Slot not free, or no vk=1: r0..r3 all 0.
REQ-017 On grant edge: y<=ag, {sel_1,sel_0}<=g, y_valid<=1, L<=g. Latency one cycle from accept to y_valid.
REQ-018 On output transfer with no grant: y_valid<=0 (FULL->EMPTY); y and sel hold their values.
REQ-019 FULL with y_ready=0: y, sel, y_valid, L all hold; no ready asserted. Upstream stalls.
REQ-020 Simultaneous output transfer and grant: new word replaces old on the same edge; sustained throughput one word per cycle.
REQ-021 rk never depends on vk of the same channel beyond the grant choice; rk=1 only for the granted channel.
REQ-022 Fairness: with all four channels continuously valid and y_ready=1, grant sequence rotates 0,1,2,3,0,... after reset; no channel waits more than 3 grants.
REQ-023 Pointer wrap: L=3 searches 0,1,2,3; no other wrap state.
REQ-024 Data is passed unmodified; no width conversion, no reordering within a channel.
REQ-025 Inputs changing while not granted have no effect on state.

Reset
REQ-026 While rst=1 at a rising edge: y_valid<=0, y<=0, sel_1<=0, sel_0<=0, L<=3 (first grant favours channel 0).
REQ-027 While rst=1: r0..r3 forced to 0 combinationally; no transfer is accepted.
REQ-028 Reset mid-operation discards any word held in y; nothing granted in the reset cycle is lost to upstream, since r=0.
REQ-029 First grant possible on the first edge after rst falls.

Verification
REQ-030 Reset, then v1=1 only, a1=0x5A, y_ready=1 -> r1=1 in that cycle; next cycle y=0x5A, sel=01, y_valid=1.
REQ-031 All v=1 with a0..a3=0x10,0x11,0x12,0x13, y_ready=1 for 8 cycles -> y sequence 0x10,0x11,0x12,0x13,0x10,... with sel 00,01,10,11,..., y_valid continuously 1.
REQ-032 FULL with y=0x22, y_ready=0 for 5 cycles while v0..v3=1 -> y, sel and y_valid constant; r0..r3=0 throughout.
REQ-033 L=3, v3=1 and v0=1 together -> channel 0 granted; next free slot grants channel 3.
REQ-034 rst=1 asserted while y_valid=1 and y_ready=0 -> after that edge y_valid=0, y=0, sel=00; next grant with all v=1 picks channel 0.
REQ-035 No valid inputs, y_ready=1 after one word -> y_valid drops to 0 one cycle after the output transfer; y retains last value.
